p0011_scan_ctrl: RTL and testbench
==================================

# p0011_scan_ctrl

Sequencing controller for the Problem 11 solver: walks every 4-cell window (right, down, down-right, down-left) of an N×N grid held in a 1-cycle-latency ROM. It issues ROM reads one cell per cycle, accumulates the window product on a single shared multiplier, and tracks the running maximum. It replaces the free-running scan loop with a start/done-controlled engine. It reports `result`/`done`/`error` the same way as the other solvers.

## Interface
- `N`, 20, grid side; N ≥ 4.
- `W`, 8, grid value width.
- `MAX_VAL`, 99, largest legal cell value.
- `ADDR_W`, $clog2(N*N), ROM address width.
- `clk` input 1 — single clock, all logic on rising edge.
- `rst_n` input 1 — synchronous, active-low reset.
- `start` input 1 — begin scan; sampled only in IDLE, DONE, ERR.
- `rom_addr` output ADDR_W — row-major cell address r*N+c.
- `rom_data` input W — data for the `rom_addr` of the previous cycle.
- `result` output 4W — maximum window product.
- `best_addr` output ADDR_W — address of first cell of best window.
- `best_dir` output 2 — direction of best window: 0 right, 1 down, 2 down-right, 3 down-left.
- `busy` output 1 — high from the cycle after start is accepted until DONE/ERR.
- `done` output 1 — scan complete, level, held until next start or reset.
- `error` output 1 — illegal cell value seen, level, held until next start or reset.

## Operation
- States: IDLE, ADV, RD, LAST, CMP, DONE, ERR.
- Reset: state IDLE. `result`, `best_addr`, `best_dir`, `rom_addr` = 0. `busy`, `done`, `error` = 0. Indices r, c, d = 0.
- IDLE/DONE/ERR + start=1:
  - Clear r, c, d, `result`, `best_*`, `done`, `error`.
  - Go ADV.
- ADV: check bounds for (r, c, d).
  - d0 requires c ≤ N-4.
  - d1 requires r ≤ N-4.
  - d2 requires both.
  - d3 requires r ≤ N-4 and c ≥ 3.
  - Valid: acc ← 1, k ← 0, go RD.
  - Invalid: advance indices and stay in ADV. If this was the last position, go DONE.
- RD (4 cycles, k = 0..3):
  - Drive `rom_addr` for cell k: d0 (r, c+k), d1 (r+k, c), d2 (r+k, c+k), d3 (r+k, c−k).
  - For k ≥ 1, acc ← acc × `rom_data` (the cell k−1 value).
  - After k = 3, go LAST.
- LAST: acc ← acc × `rom_data` (cell 3); go CMP.
- CMP:
  - If acc > `result` (strict), update `result`, `best_addr`, `best_dir`. Ties keep the earlier window.
  - Advance indices. Go ADV, or DONE if this was the last position.
- Index order: d innermost, then c, then r. Last position is (N-1, N-1, 3).
- Range check: any `rom_data` > MAX_VAL consumed in RD/LAST → go ERR and set `error`=1. `result` is frozen at its last value.
- Arithmetic: acc is 4W bits. Product of four W-bit values fits without truncation.
- `start` while busy is ignored. Reset mid-scan returns to the reset state on the next edge, with no partial result kept.

## Timing
- Valid window costs 7 cycles (ADV + 4 RD + LAST + CMP). Invalid position costs 1 cycle (ADV).
- For N = 20:
  - 1258 valid windows, 342 invalid positions → 9148 scan cycles.
  - `done` rises at the 9149th rising edge after the edge that samples `start`.
- For N = 4: 10 valid, 54 invalid → 124 scan cycles; `done` at edge 125.
- `done` and `busy` are mutually exclusive. `busy` falls on the same edge that `done`/`error` rises.
- `rom_addr` changes only in RD; it holds otherwise.

## Structure
- Package `p0011_pkg`: state enum, direction encoding (DIR_RIGHT/DOWN/DR/DL), default N/W/MAX_VAL.
- Sub-module `p0011_win_addr`: combinational block taking (r, c, d, k) and producing address and in-bounds flag. The controller instantiates one.
- The multiplier is a single shared combinational `acc*rom_data`; no second multiplier.

## Test plan
- N=4, grid 1..16 row-major, start pulse:
  - `done` at edge 125, `result`=43680, `best_addr`=12, `best_dir`=0, `error`=0.
- N=20, all cells 1:
  - `result`=1, `best_addr`=0, `best_dir`=0, `done` at edge 9149.
- N=20, zeros except 99 at (5,5),(6,6),(7,7),(8,8):
  - `result`=96059601, `best_addr`=105, `best_dir`=2.
- N=20, cell 37 = 100:
  - `error`=1 and state ERR on first read of cell 37, `done`=0.
  - A new start clears `error`.
- Start pulses during scan: ignored, identical final result and timing.
- Reset asserted mid-scan, then released:
  - All outputs 0 on the edge after reset assertion.
  - A following start gives a full, correct scan.

Source files
------------

// File: rtl/p0011_pkg.sv
// p0011_pkg: shared state, direction encoding and defaults for the Problem 11 scan controller.
package p0011_pkg;
    localparam int N_DEF = 20;
    localparam int W_DEF = 8;
    localparam int MAX_DEF = 99;
    localparam logic [1:0] DIR_RIGHT = 2'd0, DIR_DOWN = 2'd1, DIR_DR = 2'd2, DIR_DL = 2'd3;
    typedef enum logic [2:0] {S_IDLE, S_ADV, S_RD, S_LAST, S_CMP, S_DONE, S_ERR} state_t;
endpackage

// File: rtl/p0011_win_addr.sv
// p0011_win_addr: row-major address of cell k of window (r, c, d) and whether that window fits the grid.
module p0011_win_addr import p0011_pkg::*; #(
    parameter int N = N_DEF,
    parameter int ADDR_W = $clog2(N*N),
    parameter int IW = $clog2(N)
) (
    input  logic [IW-1:0] r,
    input  logic [IW-1:0] c,
    input  logic [1:0] d,
    input  logic [1:0] k,
    output logic [ADDR_W-1:0] addr,
    output logic ok
);
    int row, col;
    logic r_ok, c_ok;
    always_comb begin
        r_ok = int'(r) <= N - 4;
        c_ok = int'(c) <= N - 4;
        row = int'(r) + (d == DIR_RIGHT ? 0 : int'(k));
        col = int'(c) + (d == DIR_DOWN ? 0 : d == DIR_DL ? -int'(k) : int'(k));
        addr = ADDR_W'(row * N + col);
        ok = d == DIR_RIGHT ? c_ok : d == DIR_DOWN ? r_ok : d == DIR_DR ? r_ok && c_ok : r_ok && int'(c) >= 3;
    end
endmodule

// File: rtl/p0011_scan_ctrl.sv
// p0011_scan_ctrl: start/done-driven scan of every 4-cell window of an N x N ROM grid,
// one shared multiplier, tracking the maximum product and where it was found.
module p0011_scan_ctrl import p0011_pkg::*; #(
    parameter int N = N_DEF,
    parameter int W = W_DEF,
    parameter int MAX_VAL = MAX_DEF,
    parameter int ADDR_W = $clog2(N*N)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [W-1:0] rom_data,
    output logic [4*W-1:0] result,
    output logic [ADDR_W-1:0] best_addr,
    output logic [1:0] best_dir,
    output logic busy,
    output logic done,
    output logic error
);
    localparam int IW = $clog2(N);
    localparam int AW = 4 * W;
    state_t state, next;
    logic [IW-1:0] r, c, nr, nc;
    logic [1:0] d, k, nd;
    logic [AW-1:0] acc, prod;
    logic [ADDR_W-1:0] win, addr_q;
    logic ok, last, bad, go;

    p0011_win_addr #(.N(N), .ADDR_W(ADDR_W), .IW(IW)) u_win (
        .r(r), .c(c), .d(d), .k(k), .addr(win), .ok(ok)
    );

    always_comb begin
        go = start && (state == S_IDLE || state == S_DONE || state == S_ERR);
        last = int'(r) == N - 1 && int'(c) == N - 1 && d == DIR_DL;
        bad = int'(rom_data) > MAX_VAL;
        prod = acc * AW'(rom_data);
        nd = d + 2'd1;
        nc = d == DIR_DL ? (int'(c) == N - 1 ? '0 : c + IW'(1)) : c;
        nr = d == DIR_DL && int'(c) == N - 1 ? r + IW'(1) : r;
    end

    always_ff @(posedge clk)
        state <= !rst_n ? S_IDLE : next;

    always_comb begin
        next = state;
        case (state)
            S_IDLE, S_DONE, S_ERR: next = start ? S_ADV : state;
            S_ADV:  next = ok ? S_RD : last ? S_DONE : S_ADV;
            S_RD:   next = k != 2'd0 && bad ? S_ERR : k == 2'd3 ? S_LAST : S_RD;
            S_LAST: next = bad ? S_ERR : S_CMP;
            S_CMP:  next = last ? S_DONE : S_ADV;
            default: next = S_IDLE;
        endcase
    end

    // rom_addr follows the window only while reading so it holds between windows
    always_comb
        rom_addr = state == S_RD ? win : addr_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r <= '0; c <= '0; d <= '0; k <= '0;
            acc <= '0; addr_q <= '0;
            result <= '0; best_addr <= '0; best_dir <= '0;
            busy <= 1'b0; done <= 1'b0; error <= 1'b0;
        end else begin
            busy <= state == S_ADV || state == S_RD || state == S_LAST || state == S_CMP;
            done <= state == S_DONE && !go;
            error <= state == S_ERR && !go;
            if (go) begin
                r <= '0; c <= '0; d <= '0;
                result <= '0; best_addr <= '0; best_dir <= '0;
            end
            if (state == S_ADV) begin
                acc <= AW'(1);
                k <= '0;
                if (!ok) begin
                    r <= nr; c <= nc; d <= nd;
                end
            end
            if (state == S_RD) begin
                addr_q <= win;
                k <= k + 2'd1;
                if (k != 2'd0)
                    acc <= prod;
            end
            if (state == S_LAST)
                acc <= prod;
            // k has wrapped to 0 here, so win is the window's first cell
            if (state == S_CMP) begin
                if (acc > result) begin
                    result <= acc; best_addr <= win; best_dir <= d;
                end
                r <= nr; c <= nc; d <= nd;
            end
        end
    end
endmodule

// File: tb/tb_p0011_scan_ctrl.sv
// tb_p0011_scan_ctrl: N=4 and N=20 controllers against a behavioural window-scan model,
// directed grids plus $urandom grids, start noise, injected bad cells and mid-scan reset.
module tb_p0011_scan_ctrl;
    logic clk = 0, rst_n = 0, start4 = 0, start20 = 0;
    logic [3:0] a4, ba4;
    logic [8:0] a20, ba20;
    logic [7:0] d4, d20;
    logic [31:0] res4, res20, o_res;
    logic [1:0] bd4, bd20, o_dir;
    logic busy4, done4, err4, busy20, done20, err20, o_busy, o_done, o_err;
    int o_addr, o_ra;
    int grid[400];
    int n = 4;
    int checks = 0, failures = 0;

    p0011_scan_ctrl #(.N(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .rom_addr(a4), .rom_data(d4),
        .result(res4), .best_addr(ba4), .best_dir(bd4), .busy(busy4), .done(done4), .error(err4)
    );
    p0011_scan_ctrl #(.N(20)) dut20 (
        .clk(clk), .rst_n(rst_n), .start(start20), .rom_addr(a20), .rom_data(d20),
        .result(res20), .best_addr(ba20), .best_dir(bd20), .busy(busy20), .done(done20), .error(err20)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        d4 <= 8'(grid[a4]);
        d20 <= 8'(grid[a20]);
    end

    always_comb begin
        o_res = n == 20 ? res20 : res4;
        o_addr = n == 20 ? int'(ba20) : int'(ba4);
        o_ra = n == 20 ? int'(a20) : int'(a4);
        o_dir = n == 20 ? bd20 : bd4;
        o_busy = n == 20 ? busy20 : busy4;
        o_done = n == 20 ? done20 : done4;
        o_err = n == 20 ? err20 : err4;
    end

    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic set_start(input logic v);
        if (n == 20) start20 = v;
        else start4 = v;
    endtask

    // expected max, location, error and edge (after the start edge) at which done/error shows
    task automatic model(output longint res, output int ba, output int bd, output bit err, output int t);
        int s = 0;
        res = 0; ba = 0; bd = 0; err = 0; t = 0;
        for (int r = 0; r < n && !err; r++)
            for (int c = 0; c < n && !err; c++)
                for (int d = 0; d < 4 && !err; d++) begin
                    bit ok = d == 0 ? c <= n - 4 : d == 1 ? r <= n - 4 :
                             d == 2 ? (r <= n - 4 && c <= n - 4) : (r <= n - 4 && c >= 3);
                    longint p = 1;
                    if (!ok) begin
                        s++;
                        continue;
                    end
                    for (int k = 0; k < 4; k++) begin
                        int rr = r + (d == 0 ? 0 : k);
                        int cc = c + (d == 1 ? 0 : d == 3 ? -k : k);
                        if (grid[rr * n + cc] > 99) begin
                            err = 1;
                            t = s + 4 + k;
                            break;
                        end
                        p *= grid[rr * n + cc];
                    end
                    if (err) break;
                    if (p > res) begin
                        res = p; ba = r * n + c; bd = d;
                    end
                    s += 7;
                end
        if (!err) t = s + 1;
    endtask

    task automatic scan(input string tag, input bit noise, output int cnt);
        longint er;
        int ea, ed, et;
        bit ee, excl = 1;
        model(er, ea, ed, ee, et);
        @(negedge clk) set_start(1);
        @(negedge clk) set_start(0);
        cnt = 0;
        while (cnt < 20000) begin
            @(posedge clk);
            #1;
            cnt++;
            if (o_busy && o_done) excl = 0;
            if (cnt == 1) check({tag, "_start"}, {o_busy, o_done, o_err}, 3'b100);
            if (o_done || o_err) break;
            set_start(noise && cnt < et - 3 ? 1'($urandom % 2) : 1'b0);
        end
        set_start(0);
        check({tag, "_cyc"}, cnt, et);
        check({tag, "_err"}, o_err, ee);
        check({tag, "_done"}, o_done, !ee);
        check({tag, "_busy"}, o_busy, 0);
        check({tag, "_res"}, o_res, er);
        check({tag, "_addr"}, o_addr, ea);
        check({tag, "_dir"}, o_dir, ed);
        check({tag, "_excl"}, excl, 1);
    endtask

    task automatic reset_outs(input string tag);
        check({tag, "_res"}, o_res, 0);
        check({tag, "_addr"}, o_addr, 0);
        check({tag, "_dir"}, o_dir, 0);
        check({tag, "_ra"}, o_ra, 0);
        check({tag, "_flags"}, {o_busy, o_done, o_err}, 0);
    endtask

    task automatic fill_random(input bit inject);
        for (int i = 0; i < n * n; i++) grid[i] = $urandom_range(0, 99);
        if (inject) grid[$urandom_range(0, n * n - 1)] = $urandom_range(100, 255);
    endtask

    initial begin
        int cnt;
        repeat (3) @(posedge clk);
        #1;
        n = 4;
        #1 reset_outs("rst4");
        n = 20;
        #1 reset_outs("rst20");
        @(negedge clk) rst_n = 1;

        n = 4;
        for (int i = 0; i < 16; i++) grid[i] = i + 1;
        scan("n4_seq", 0, cnt);
        check("n4_seq_t125", cnt, 125);
        check("n4_seq_43680", o_res, 43680);
        check("n4_seq_a12", o_addr, 12);
        for (int i = 0; i < 6; i++) begin
            fill_random($urandom % 3 == 0);
            scan($sformatf("n4_rnd%0d", i), i[0], cnt);
        end

        n = 20;
        for (int i = 0; i < 400; i++) grid[i] = 1;
        scan("ones", 0, cnt);
        check("ones_t9149", cnt, 9149);
        check("ones_r1", o_res, 1);

        for (int i = 0; i < 400; i++) grid[i] = 0;
        for (int i = 5; i < 9; i++) grid[i * 20 + i] = 99;
        scan("diag", 0, cnt);
        check("diag_val", o_res, 96059601);
        check("diag_a105", o_addr, 105);
        check("diag_d2", o_dir, 2);

        for (int i = 0; i < 400; i++) grid[i] = 1;
        grid[37] = 100;
        scan("bad37", 0, cnt);
        check("bad37_e", o_err, 1);

        fill_random(0);
        scan("noise", 1, cnt);

        fill_random(0);
        @(negedge clk) set_start(1);
        @(negedge clk) set_start(0);
        repeat ($urandom_range(50, 3000)) @(negedge clk);
        rst_n = 0;
        @(posedge clk);
        #1 reset_outs("midrst");
        @(negedge clk) rst_n = 1;
        scan("after_rst", 0, cnt);

        fill_random(1);
        scan("inject", 0, cnt);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
